// File: rtl/ram_responder_if.sv
// ram_responder_if: memory bus between an initiator and the RAM responder
interface ram_responder_if;
    logic [15:0] address;
    logic [31:0] data_in;
    logic [3:0]  write_mask;
    logic        bus_enable;
    logic        write_enable;
    logic [31:0] data_out;
    logic        data_ready;
    logic        hit;

    modport master (
        output address, data_in, write_mask, bus_enable, write_enable,
        input  data_out, data_ready, hit
    );

    modport slave (
        input  address, data_in, write_mask, bus_enable, write_enable,
        output data_out, data_ready, hit
    );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: windowed word RAM with byte-masked writes, registered reads and data_ready handshake; RAM_ZERO_ON_RESET_EN adds a zero-fill CLEAR state after reset
module ram_responder #(
    parameter logic [15:0] BASE_ADDR  = 16'hc000,
    parameter int          DEPTH_LOG2 = 10
) (
    input logic            raw_clk,
    input logic            button_reset,
    ram_responder_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
`ifdef RAM_ZERO_ON_RESET_EN
    localparam logic [1:0] CLEAR     = 2'd3;
    localparam logic [1:0] RST_STATE = CLEAR;
`else
    localparam logic [1:0] RST_STATE = IDLE;
`endif

    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            mask_q, mask_d;
    logic                  we_q, we_d;
    logic [31:0]           dout_q, dout_d;
    logic                  ready_q, ready_d;
`ifdef RAM_ZERO_ON_RESET_EN
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
`endif
    logic                  unused_addr;

    assign bus.hit        = bus.address[15:DEPTH_LOG2+2] == BASE_ADDR[15:DEPTH_LOG2+2];
    assign bus.data_out   = dout_q;
    assign bus.data_ready = ready_q;
    assign unused_addr    = ^bus.address[1:0];

    // Next-state: latch the request on a hit, access once, hold until the initiator releases
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        we_d    = we_q;
        dout_d  = dout_q;
        ready_d = ready_q;
`ifdef RAM_ZERO_ON_RESET_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: if (bus.bus_enable && bus.hit) begin
                idx_d   = bus.address[DEPTH_LOG2+1:2];
                wdata_d = bus.data_in;
                mask_d  = bus.write_mask;
                we_d    = bus.write_enable;
                state_d = ACCESS;
            end
            ACCESS: begin
                dout_d  = we_q ? dout_q : mem[idx_q];
                ready_d = 1'b1;
                state_d = DONE;
            end
            DONE: if (!bus.bus_enable) begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
`ifdef RAM_ZERO_ON_RESET_EN
            CLEAR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == '1) ? IDLE : CLEAR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset drops any access in flight
    always_ff @(posedge raw_clk) begin
        if (!button_reset) begin
            state_q <= RST_STATE;
            idx_q   <= '0;
            wdata_q <= '0;
            mask_q  <= '1;
            we_q    <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
`ifdef RAM_ZERO_ON_RESET_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            we_q    <= we_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
`ifdef RAM_ZERO_ON_RESET_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Array writes: byte lanes with an active-low mask, suppressed while reset is low
    always_ff @(posedge raw_clk) begin
        if (button_reset && state_q == ACCESS && we_q) begin
            for (int i = 0; i < 4; i++)
                if (!mask_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
`ifdef RAM_ZERO_ON_RESET_EN
        else if (button_reset && state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end
`endif
    end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: scoreboard bench for ram_responder; also covers the RAM_ZERO_ON_RESET_EN build
module tb_ram_responder;
`ifdef RAM_ZERO_ON_RESET_EN
    localparam int DL = 4;
`else
    localparam int DL = 10;
`endif
    localparam logic [15:0] BASE = 16'hc000;
    localparam int          WIN  = 4 << DL;

    typedef struct {
        logic [31:0] data;
        int          req_cyc;
    } exp_t;

    logic raw_clk = 0;
    logic button_reset;
    ram_responder_if bus();

    ram_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL)) dut (
        .raw_clk(raw_clk),
        .button_reset(button_reset),
        .bus(bus)
    );

    always #5 raw_clk = ~raw_clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_ready = 0;
    logic [31:0] exp_dout = 0;

    always @(posedge raw_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every rising data_ready must match the oldest outstanding request
    always @(negedge raw_clk) begin
        if (bus.data_ready && !prev_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual=1 required=0 at cyc %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_out", bus.data_out, e.data);
                chk("latency", cyc - e.req_cyc, 1);
            end
        end
        prev_ready <= bus.data_ready;
    end

    task automatic access(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                          input logic we, input logic [31:0] rd_exp);
        exp_t e;
        bit   got;
        @(negedge raw_clk);
        bus.address = a; bus.data_in = d; bus.write_mask = m; bus.write_enable = we;
        bus.bus_enable = 1;
        if (!we) exp_dout = rd_exp;
        e.data = exp_dout;
        e.req_cyc = cyc + 1;
        sb.push_back(e);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge raw_clk);
            got = bus.data_ready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1 addr=%h", a);
            void'(sb.pop_front());
        end
        bus.bus_enable = 0;
        @(negedge raw_clk);
        chk("release", {31'b0, bus.data_ready}, 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge raw_clk);
        button_reset = 0;
        bus.bus_enable = 0;
        repeat (n) @(negedge raw_clk);
        button_reset = 1;
`ifdef RAM_ZERO_ON_RESET_EN
        repeat ((1 << DL) + 2) @(negedge raw_clk);
`endif
    endtask

    initial begin
        bit seen;
        button_reset = 0;
        bus.address = 0; bus.data_in = 0; bus.write_mask = 4'hf;
        bus.bus_enable = 0; bus.write_enable = 0;
        repeat (3) @(negedge raw_clk);
        chk("rst_ready", {31'b0, bus.data_ready}, 32'd0);
        chk("rst_dout", bus.data_out, 32'd0);
        button_reset = 1;
`ifdef RAM_ZERO_ON_RESET_EN
        bus.address = 16'hc000; bus.write_enable = 0; bus.bus_enable = 1;
        seen = 0;
        repeat (14) begin
            @(negedge raw_clk);
            seen |= bus.data_ready;
        end
        bus.bus_enable = 0;
        chk("clear_ignores_req", {31'b0, seen}, 32'd0);
        repeat (6) @(negedge raw_clk);
        access(16'hc03c, 0, 4'hf, 0, 32'h0);
`endif
        bus.address = BASE - 16'd1;
        #1 chk("hit_below", {31'b0, bus.hit}, 32'd0);
        bus.address = BASE;
        #1 chk("hit_base", {31'b0, bus.hit}, 32'd1);
        bus.address = BASE + 16'(WIN - 1);
        #1 chk("hit_top", {31'b0, bus.hit}, 32'd1);
        bus.address = BASE + 16'(WIN);
        #1 chk("hit_above", {31'b0, bus.hit}, 32'd0);

        access(16'hc010, 32'hdeadbeef, 4'b0000, 1, 0);
        access(16'hc010, 0, 4'hf, 0, 32'hdeadbeef);
        access(16'hc011, 32'h5a5a5a5a, 4'b1101, 1, 0);
        chk("dout_after_write", bus.data_out, 32'hdeadbeef);
        access(16'hc010, 0, 4'hf, 0, 32'hdead5aef);

        @(negedge raw_clk);
        bus.address = 16'h4000; bus.write_enable = 0; bus.bus_enable = 1;
        seen = 0;
        repeat (10) begin
            @(negedge raw_clk);
            seen |= bus.data_ready;
        end
        chk("miss_hit", {31'b0, bus.hit}, 32'd0);
        chk("miss_ready", {31'b0, seen}, 32'd0);
        chk("miss_dout", bus.data_out, 32'hdead5aef);
        bus.bus_enable = 0;

        @(negedge raw_clk);
        bus.address = 16'hc000; bus.data_in = 32'h1; bus.write_mask = 0;
        bus.write_enable = 1; bus.bus_enable = 1;
        begin
            exp_t e;
            e.data = exp_dout;
            e.req_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge raw_clk);
        bus.data_in = 32'h2;
        repeat (19) @(negedge raw_clk);
        chk("held_ready", {31'b0, bus.data_ready}, 32'd1);
        bus.bus_enable = 0;
        @(negedge raw_clk);
        chk("held_release", {31'b0, bus.data_ready}, 32'd0);
        access(16'hc000, 0, 4'hf, 0, 32'h1);

        access(16'hc000, 32'hffffffff, 4'b1111, 1, 0);
        access(16'hc000, 0, 4'hf, 0, 32'h1);

        access(16'hc004, 32'h0, 4'b0000, 1, 0);
        @(negedge raw_clk);
        bus.address = 16'hc004; bus.data_in = 32'hffffffff; bus.write_mask = 0;
        bus.write_enable = 1; bus.bus_enable = 1;
        @(negedge raw_clk);
        button_reset = 0;
        @(negedge raw_clk);
        chk("rst_access_ready", {31'b0, bus.data_ready}, 32'd0);
        chk("rst_access_dout", bus.data_out, 32'd0);
        exp_dout = 0;
        do_reset(1);
        access(16'hc004, 0, 4'hf, 0, 32'h0);

        repeat (4) @(negedge raw_clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_responder.md
# ram_responder

Word-organised RAM target for the CPU's memory bus: decodes a 16-bit byte address against its window, performs byte-masked writes and registered reads, and signals completion with a `data_ready` handshake. It sits on the responder side of the bus, alongside the ROM and peripheral decode. It gives the bus a waitable RAM region in place of the current fixed-latency access.

## Interface

Parameters:
- `BASE_ADDR`, 16'hc000: byte base of the RAM window; must be aligned to the window size.
- `DEPTH_LOG2`, 10: log2 of the word count (1024 words = 4 KB); legal range 2..13.

Ports:
- `raw_clk`  in  1  clock; all logic on the rising edge.
- `button_reset`  in  1  synchronous, active-low reset.
- `address`  in  16  byte address from the initiator.
- `data_in`  in  32  write data; lanes are already replicated or positioned by the initiator.
- `write_mask`  in  4  per-byte mask, active-low: bit i = 0 writes byte lane i.
- `bus_enable`  in  1  request strobe; held high by the initiator until it sees `data_ready`.
- `write_enable`  in  1  1 = write, 0 = read; sampled at acceptance.
- `data_out`  out  32  read data, registered.
- `data_ready`  out  1  access complete; held until `bus_enable` drops.
- `hit`  out  1  combinational: `address` falls inside the window.

## Operation

- Window decode: `hit = address[15:DEPTH_LOG2+2] == BASE_ADDR[15:DEPTH_LOG2+2]`.
- Word index is `address[DEPTH_LOG2+1:2]`. `address[1:0]` is ignored; lane selection is carried entirely by `write_mask`.
- States:
  - IDLE: if `bus_enable && hit`, latch word index, `data_in`, `write_mask` and `write_enable`, then go to ACCESS. Otherwise stay; misses are never answered.
  - ACCESS:
    - Write: for each i with `write_mask[i]==0`, `mem[idx][8i+7:8i] <= data_in[8i+7:8i]`. `data_out` is unchanged.
    - Read: `data_out <= mem[idx]`.
    - In both cases `data_ready <= 1` and go to DONE.
  - DONE: hold `data_out` and `data_ready`. When `bus_enable==0`, set `data_ready <= 0` and go to IDLE.
  - CLEAR: only when `RAM_ZERO_ON_RESET_EN` is defined; see Configuration.
- Input changes after acceptance (address, data, mask, `write_enable`) have no effect on the access in flight.
- A write with `write_mask == 4'b1111` is a legal no-op: it completes normally with `data_ready`.
- Reset values: `data_out = 0`, `data_ready = 0`, state IDLE, or CLEAR if the macro is defined.
- Reset has priority over every state. An access in flight is dropped. If `button_reset` is low on the ACCESS edge, no RAM write is committed.

## Timing

- Request seen high on edge k (state IDLE) → ACCESS after edge k → array access and `data_ready=1` after edge k+1. Latency is 2 edges.
- `bus_enable` low on edge m while in DONE → `data_ready=0` after edge m; IDLE can accept again from edge m+1.
- Minimum request-to-request spacing is 4 edges: accept, access, release, re-accept.
- Each assertion of `bus_enable` gets exactly one access. Holding `bus_enable` high in DONE never starts a second access.
- If `bus_enable` drops during ACCESS, the access still completes. DONE then releases on the next edge.
- Read-after-write to the same word returns the new data, because the write commits before the next acceptance.
- `hit` is combinational from `address` with no state dependency.

## Configuration

- `RAM_ZERO_ON_RESET_EN` defined:
  - Reset enters CLEAR. A word counter starts at 0 and writes 32'h0 to one word per edge.
  - After the write to word `2^DEPTH_LOG2 - 1`, the block goes to IDLE.
  - Requests are ignored and `data_ready` stays 0 throughout CLEAR. Clearing takes `2^DEPTH_LOG2` edges.
  - A reset asserted during CLEAR restarts the counter at 0.
- Not defined: there is no CLEAR state and RAM contents after reset are undefined. IDLE is entered on the first edge after reset releases.

## Test plan

- Write 32'hdeadbeef to 16'hc010 with mask 4'b0000, drop `bus_enable`, then read 16'hc010 → `data_ready` 2 edges after each request; read returns 32'hdeadbeef.
- Write `data_in` 32'h5a5a5a5a, mask 4'b1101 to 16'hc011 over a word holding 32'hdeadbeef → read returns 32'hdead5aef.
- Read 16'h4000 (miss) held for 10 edges → `hit=0`, `data_ready` stays 0, `data_out` unchanged.
- Hold `bus_enable` high for 20 edges after a write of 32'h1 to 16'hc000, changing `data_in` to 32'h2 meanwhile → exactly one write, and a later read returns 32'h1.
- Pull `button_reset` low on the ACCESS edge of a write of 32'hffffffff to 16'hc004 whose prior content is 32'h0 → `data_ready` stays 0; with the macro defined a later read returns 32'h0.
- With `RAM_ZERO_ON_RESET_EN` and `DEPTH_LOG2=4` → a request during the 16 CLEAR edges gets no response; after clearing, a read of 16'hc03c returns 32'h0 with 2-edge latency.
